adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `Adder` instance among `NUM_REQ` requesters in the single-cycle core's support logic, e.g. branch-target, address-generation and debug units. It accepts at most one request at a time and registers the operands into the shared adder. It captures the sum and returns it, tagged with the requester index, over a valid/ready response channel. The `Adder` instance stays outside this block, connected through `add_op1`/`add_op2`/`add_y`.

---
 rtl/adder_arbiter.sv | 134 +++++++++++++
 tb/tb_adder_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sequencer sharing one external adder among requesters
module adder_arbiter #(
  parameter int OPERAND_WIDTH = 32,
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_op2,
  output logic [OPERAND_WIDTH-1:0]         add_op1,
  output logic [OPERAND_WIDTH-1:0]         add_op2,
  input  logic [OPERAND_WIDTH-1:0]         add_y,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [OPERAND_WIDTH-1:0]         rsp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state_q, state_d;
  logic [ID_W-1:0]          ptr_q;
  logic [ID_W-1:0]          grant;
  logic [ID_W-1:0]          ptr_next;
  logic                     any_valid;
  logic                     accept;
  logic [2*NUM_REQ-1:0]     dbl_valid;
  logic [NUM_REQ-1:0]       rot_valid;
  logic [ID_W:0]            idx_sum;
  logic [OPERAND_WIDTH-1:0] sel_op1, sel_op2;
  logic [OPERAND_WIDTH-1:0] op1_q, op2_q;
  logic [ID_W-1:0]          id_q;

  // Rotate req_valid so bit 0 is the requester at ptr; the first set bit is the grant.
  always_comb begin
    dbl_valid = {req_valid, req_valid};
    rot_valid = NUM_REQ'(dbl_valid >> ptr_q);
    grant     = '0;
    any_valid = 1'b0;
    idx_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        idx_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
          idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
        end
        grant     = idx_sum[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  end

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == ID_W'(k)) begin
        sel_op1 = req_op1[k*OPERAND_WIDTH +: OPERAND_WIDTH];
        sel_op2 = req_op2[k*OPERAND_WIDTH +: OPERAND_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accept is gated by rst so nothing is granted while reset is held.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (any_valid && !rst) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = accept && (grant == ID_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        op1_q <= sel_op1;
        op2_q <= sel_op2;
        id_q  <= grant;
        ptr_q <= ptr_next;
      end
      if (state_q == EXEC) begin
        rsp_data  <= add_y;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Adder inputs come straight from registers so they are stable for the whole EXEC cycle.
  assign add_op1 = op1_q;
  assign add_op2 = op2_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - table-driven scoreboard bench for adder_arbiter
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_op1, req_op2;
  logic [31:0]  add_op1, add_op2, add_y;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]   mask;
    logic [127:0] op1;
    logic [127:0] op2;
    int           exp_id;
    logic [31:0]  exp_data;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;

  adder_arbiter #(.OPERAND_WIDTH(32), .NUM_REQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .add_op1(add_op1), .add_op2(add_op2), .add_y(add_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Stand-in for the shared Adder.
  assign add_y = add_op1 + add_op2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got id %0d data %h, required no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] m, input int ia, input logic [31:0] a1, input logic [31:0] a2,
                              input int ib, input logic [31:0] b1, input logic [31:0] b2,
                              input int eid, input logic [31:0] ed);
    vec_t v;
    v.mask = m;
    v.op1 = '0;
    v.op2 = '0;
    v.op1[ia*32 +: 32] = a1;
    v.op2[ia*32 +: 32] = a2;
    v.op1[ib*32 +: 32] = b1;
    v.op2[ib*32 +: 32] = b2;
    v.exp_id = eid;
    v.exp_data = ed;
    return v;
  endfunction

  task automatic push_exp(input int id, input logic [31:0] data);
    exp_t e;
    e.id = 2'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int t;
    t = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    g = req_ready;
  endtask

  task automatic scramble_ops();
    req_op1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_op2 = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic apply_vec(input vec_t v);
    logic [3:0] g;
    logic [3:0] want;
    want = 4'b0001 << v.exp_id;
    req_valid = v.mask;
    req_op1 = v.op1;
    req_op2 = v.op2;
    wait_grant(g);
    chk("req_ready", 64'(g), 64'(want));
    push_exp(v.exp_id, v.exp_data);
    @(posedge clk); #1;
    req_valid = '0;
    scramble_ops();
    @(negedge clk);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("resp_rsp_valid", 64'(rsp_valid), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    vec_t vt[8];
    logic [3:0] g;
    int last_cyc;

    vt[0] = mk(4'b0100, 2, 32'h5, 32'h7, 2, 32'h5, 32'h7, 2, 32'h0000_000C);
    vt[1] = mk(4'b0001, 0, 32'hFFFF_FFFF, 32'h1, 0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0);
    vt[2] = mk(4'b0011, 0, 32'h1, 32'h1, 1, 32'h8000_0000, 32'h8000_0000, 1, 32'h0);
    vt[3] = mk(4'b0011, 0, 32'h10, 32'h20, 1, 32'h30, 32'h40, 0, 32'h30);
    vt[4] = mk(4'b0011, 0, 32'h10, 32'h20, 1, 32'h30, 32'h40, 1, 32'h70);
    vt[5] = mk(4'b1001, 0, 32'h7, 32'h8, 3, 32'h1234_5678, 32'h1111_1111, 3, 32'h2345_6789);
    vt[6] = mk(4'b1000, 3, 32'hDEAD_BEEF, 32'h1, 3, 32'hDEAD_BEEF, 32'h1, 3, 32'hDEAD_BEF0);
    vt[7] = mk(4'b1110, 1, 32'h3, 32'h4, 2, 32'h9, 32'h9, 1, 32'h7);

    rst = 1'b1;
    req_valid = '0;
    req_op1 = '0;
    req_op2 = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_add_op1", 64'(add_op1), 64'(0));
    chk("rst_add_op2", 64'(add_op2), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;

    foreach (vt[i]) apply_vec(vt[i]);
    drain();

    // All four requesters valid continuously: grants rotate 0,1,2,3,0 three cycles apart.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_op1[i*32 +: 32] = 32'(i);
      req_op2[i*32 +: 32] = 32'(100 + i);
    end
    req_valid = 4'b1111;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_grant", 64'(g), 64'(4'b0001 << (k % 4)));
      if (k > 0) chk("rr_spacing", 64'(cyc_cnt - last_cyc), 64'(3));
      last_cyc = cyc_cnt;
      push_exp(k % 4, 32'(100 + 2 * (k % 4)));
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();
    @(posedge clk); #1;

    // Backpressure: response held for 5 cycles while another requester waits.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_op1[32 +: 32] = 32'hA5A5_0000;
    req_op2[32 +: 32] = 32'h0000_5A5A;
    wait_grant(g);
    chk("bp_grant", 64'(g), 64'(4'b0010));
    push_exp(1, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    scramble_ops();
    @(negedge clk);
    chk("bp_exec_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_data", 64'(rsp_data), 64'(32'hA5A5_5A5A));
      chk("bp_id", 64'(rsp_id), 64'(1));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_released", 64'(rsp_valid), 64'(0));
    chk("bp_drained", 64'(sb.size()), 64'(0));
    @(posedge clk); #1;

    // Reset while in EXEC: the transaction vanishes without a response.
    req_valid = 4'b0010;
    req_op1[32 +: 32] = 32'h1;
    req_op2[32 +: 32] = 32'h1;
    wait_grant(g);
    chk("mid_grant", 64'(g), 64'(4'b0010));
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rsp_data", 64'(rsp_data), 64'(0));
    chk("mid_rsp_id", 64'(rsp_id), 64'(0));
    chk("mid_add_op1", 64'(add_op1), 64'(0));
    chk("mid_add_op2", 64'(add_op2), 64'(0));
    chk("mid_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    apply_vec(mk(4'b1000, 3, 32'h100, 32'h23, 3, 32'h100, 32'h23, 3, 32'h123));
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("final_idle", 64'(rsp_valid), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
